// File: rtl/ahb_lite_mem_model.sv
// Word-addressed memory behind the AHB-Lite slave's REQ/GRANT port.
// Each request waits WAIT_CYCLES, then completes with a one-cycle registered GRANT.
module ahb_lite_mem_model #(
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned MEM_DEPTH   = 256,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic [ADDR_WIDTH-1:0] ADDR_mem_i,
   input  logic                  WRITE_mem_i,
   input  logic [DATA_WIDTH-1:0] WDATA_mem_i,
   input  logic                  REQ_mem_i,
   output logic                  GRANT_mem_o,
   output logic [DATA_WIDTH-1:0] RDATA_mem_o,
   output logic [ADDR_WIDTH-1:0] MaxAddr_mem_o,
   output logic                  BUSY_mem_o
);

   localparam int unsigned IdxWidth = $clog2(MEM_DEPTH);
   localparam bit          ZeroWait = (WAIT_CYCLES == 0);
   localparam logic [3:0]  CntInit  = ZeroWait ? 4'd0 : 4'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StWait, StGnt} state_e;

   state_e                state_q;
   logic [3:0]            cnt_q;
   logic [IdxWidth-1:0]   idx_q;
   logic                  write_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic                  grant_q;
   logic                  busy_q;
   logic [DATA_WIDTH-1:0] rdata_q;

   logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

   logic                  enter_gnt;
   logic [IdxWidth-1:0]   acc_idx;
   logic                  acc_write;
   logic [DATA_WIDTH-1:0] acc_wdata;
   logic                  unused_addr;

   // Upper address bits are deliberately ignored; the slave range-checks against MaxAddr.
   assign unused_addr   = ^ADDR_mem_i;
   assign MaxAddr_mem_o = ADDR_WIDTH'(MEM_DEPTH - 1);

   // The access is performed on the edge that enters GNT; with zero wait states
   // that is the sampling edge itself, so the live inputs are used instead of the latch.
   always_comb begin
      enter_gnt = 1'b0;
      acc_idx   = idx_q;
      acc_write = write_q;
      acc_wdata = wdata_q;
      if (state_q == StIdle && REQ_mem_i && ZeroWait) begin
         enter_gnt = 1'b1;
         acc_idx   = ADDR_mem_i[IdxWidth-1:0];
         acc_write = WRITE_mem_i;
         acc_wdata = WDATA_mem_i;
      end else if (state_q == StWait && REQ_mem_i && cnt_q == 4'd0) begin
         enter_gnt = 1'b1;
      end
   end

   // Array is not reset; gating on HRESETn keeps a write from landing during reset.
   always_ff @(posedge HCLK) begin
      if (HRESETn && enter_gnt && acc_write) begin
         mem_q[acc_idx] <= acc_wdata;
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         idx_q   <= '0;
         write_q <= 1'b0;
         wdata_q <= '0;
         grant_q <= 1'b0;
         busy_q  <= 1'b0;
         rdata_q <= '0;
      end else begin
         grant_q <= 1'b0;
         if (enter_gnt && !acc_write) begin
            rdata_q <= mem_q[acc_idx];
         end
         unique case (state_q)
            StIdle: begin
               if (REQ_mem_i) begin
                  idx_q   <= ADDR_mem_i[IdxWidth-1:0];
                  write_q <= WRITE_mem_i;
                  wdata_q <= WDATA_mem_i;
                  busy_q  <= 1'b1;
                  if (ZeroWait) begin
                     state_q <= StGnt;
                     grant_q <= 1'b1;
                  end else begin
                     state_q <= StWait;
                     cnt_q   <= CntInit;
                  end
               end
            end
            StWait: begin
               if (!REQ_mem_i) begin
                  state_q <= StIdle;
                  cnt_q   <= 4'd0;
                  busy_q  <= 1'b0;
               end else if (cnt_q == 4'd0) begin
                  state_q <= StGnt;
                  grant_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            StGnt: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign GRANT_mem_o = grant_q;
   assign RDATA_mem_o = rdata_q;
   assign BUSY_mem_o  = busy_q;

endmodule

// File: tb/tb_ahb_lite_mem_model.sv
// Directed self-checking bench for ahb_lite_mem_model with the default
// parameters (WAIT_CYCLES=2, MEM_DEPTH=256).
module tb_ahb_lite_mem_model;

   logic        clk;
   logic        rst_n;
   logic [31:0] addr;
   logic        write;
   logic [31:0] wdata;
   logic        req;
   logic        grant;
   logic [31:0] rdata;
   logic [31:0] max_addr;
   logic        busy;

   int n_checks = 0;
   int n_pass   = 0;

   ahb_lite_mem_model #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .MEM_DEPTH  (256),
      .WAIT_CYCLES(2)
   ) dut (
      .HCLK         (clk),
      .HRESETn      (rst_n),
      .ADDR_mem_i   (addr),
      .WRITE_mem_i  (write),
      .WDATA_mem_i  (wdata),
      .REQ_mem_i    (req),
      .GRANT_mem_o  (grant),
      .RDATA_mem_o  (rdata),
      .MaxAddr_mem_o(max_addr),
      .BUSY_mem_o   (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // One request; wdata_late replaces WDATA after the sampling edge to show it is ignored.
   // lat counts post-edge samples up to and including the one that shows GRANT (0 = timeout).
   task automatic access(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] wd_late, output int lat, output int busy_n,
                         output logic [31:0] rd);
      addr   = a;
      write  = wr;
      wdata  = wd;
      req    = 1'b1;
      lat    = 0;
      busy_n = 0;
      rd     = '0;
      for (int i = 1; i <= 50; i++) begin
         @(posedge clk);
         #1;
         if (busy) busy_n++;
         wdata = wd_late;
         if (grant) begin
            lat = i;
            rd  = rdata;
            break;
         end
      end
      req = 1'b0;
      @(posedge clk);
      #1;
      check("grant_one_cycle", {31'd0, grant}, 32'd0);
      check("busy_after_gnt", {31'd0, busy}, 32'd0);
   endtask

   int          lat;
   int          busy_n;
   logic [31:0] rd;
   logic        g_seen;

   initial begin
      rst_n = 1'b0;
      addr  = '0;
      write = 1'b0;
      wdata = '0;
      req   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_grant", {31'd0, grant}, 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_maxaddr", max_addr, 32'h0000_00FF);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 1: write latency and BUSY width
      access(1'b1, 32'h05, 32'hDEAD_BEEF, 32'hDEAD_BEEF, lat, busy_n, rd);
      check("t1_latency", 32'(lat), 32'd3);
      check("t1_busy_cycles", 32'(busy_n), 32'd3);

      // 2: read back, data held afterwards
      access(1'b0, 32'h05, 32'h0, 32'h0, lat, busy_n, rd);
      check("t2_latency", 32'(lat), 32'd3);
      check("t2_rdata_gnt", rd, 32'hDEAD_BEEF);
      repeat (5) @(posedge clk);
      #1;
      check("t2_rdata_hold", rdata, 32'hDEAD_BEEF);

      // 3: WDATA changed mid-WAIT is ignored
      access(1'b1, 32'h10, 32'h1111_1111, 32'h2222_2222, lat, busy_n, rd);
      check("t3_wr_latency", 32'(lat), 32'd3);
      access(1'b0, 32'h10, 32'h0, 32'h0, lat, busy_n, rd);
      check("t3_rdata", rd, 32'h1111_1111);

      // 4: read aborted after one wait cycle
      addr  = 32'h05;
      write = 1'b0;
      req   = 1'b1;
      @(posedge clk);
      #1;
      check("t4_busy_wait", {31'd0, busy}, 32'd1);
      req    = 1'b0;
      g_seen = 1'b0;
      repeat (4) begin
         @(posedge clk);
         #1;
         if (grant) g_seen = 1'b1;
      end
      check("t4_no_grant", {31'd0, g_seen}, 32'd0);
      check("t4_idle", {31'd0, busy}, 32'd0);
      check("t4_rdata_kept", rdata, 32'h1111_1111);
      access(1'b0, 32'h05, 32'h0, 32'h0, lat, busy_n, rd);
      check("t4_followup_lat", 32'(lat), 32'd3);
      check("t4_followup", rd, 32'hDEAD_BEEF);

      // 5: upper address bits ignored
      access(1'b1, 32'h105, 32'hA5A5_A5A5, 32'hA5A5_A5A5, lat, busy_n, rd);
      access(1'b0, 32'h05, 32'h0, 32'h0, lat, busy_n, rd);
      check("t5_alias", rd, 32'hA5A5_A5A5);
      check("t5_maxaddr", max_addr, 32'h0000_00FF);

      // 6: reset during WAIT discards the write
      access(1'b1, 32'h07, 32'h0, 32'h0, lat, busy_n, rd);
      addr  = 32'h07;
      write = 1'b1;
      wdata = 32'h1234_5678;
      req   = 1'b1;
      @(posedge clk);
      #1;
      check("t6_busy_wait", {31'd0, busy}, 32'd1);
      check("t6_rdata_pre", rdata, 32'hA5A5_A5A5);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_rst_grant", {31'd0, grant}, 32'd0);
      check("t6_rst_rdata", rdata, 32'd0);
      check("t6_rst_busy", {31'd0, busy}, 32'd0);
      check("t6_rst_maxaddr", max_addr, 32'h0000_00FF);
      req = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      access(1'b0, 32'h07, 32'h0, 32'h0, lat, busy_n, rd);
      check("t6_latency", 32'(lat), 32'd3);
      check("t6_rdata", rd, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
